// File: rtl/mux_arb_pkg.sv
// Shared encodings for the 2:1 mux arbiter: FSM states, select values
// and a helper mapping a mux select to the matching service state.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERV_A = 2'd1,
    ST_SERV_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic state_t serv_state(input logic s);
    return (s == SEL_B) ? ST_SERV_B : ST_SERV_A;
  endfunction

endpackage

// File: rtl/mux_21_w.sv
// Width-parameterised combinational 2:1 data mux: o_q = i_s ? i_b : i_a.
module mux_21_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_s,
  output logic [WIDTH-1:0] o_q
);

  assign o_q = i_s ? i_b : i_a;

endmodule

// File: rtl/mux_21_arbiter.sv
// Round-robin owner of a shared 2:1 mux: grants A or B, bursts up to
// MAX_BURST words under contention, forwards the selected word via valid/ready.
module mux_21_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_a,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic             i_req_b,
  input  logic [WIDTH-1:0] i_data_b,
  input  logic             i_out_ready,
  output logic             o_gnt_a,
  output logic             o_gnt_b,
  output logic             o_ack_a,
  output logic             o_ack_b,
  output logic             o_sel,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data
);

  localparam logic [7:0] LP_CNT_LAST = 8'(MAX_BURST - 1);

  state_t     r_state;
  logic       r_sel;
  logic       r_last;
  logic       r_gnt_a;
  logic       r_gnt_b;
  logic [7:0] r_burst_cnt;

  logic w_serv_a;
  logic w_serv_b;
  logic w_req_own;
  logic w_req_oth;
  logic w_oth_sel;
  logic w_own_sel;
  logic w_idle_go;
  logic w_idle_sel;
  logic w_valid;
  logic w_xfer;
  logic w_at_limit;

  always_comb begin
    w_serv_a   = (r_state == ST_SERV_A);
    w_serv_b   = (r_state == ST_SERV_B);
    w_req_own  = w_serv_a ? i_req_a : i_req_b;
    w_req_oth  = w_serv_a ? i_req_b : i_req_a;
    w_own_sel  = w_serv_a ? SEL_A : SEL_B;
    w_oth_sel  = w_serv_a ? SEL_B : SEL_A;
    w_idle_go  = i_req_a | i_req_b;
    // A wins a tie only when B was the side served last.
    w_idle_sel = (i_req_a && (!i_req_b || (r_last == SEL_B))) ? SEL_A : SEL_B;
    // Reset masks the handshake so an in-flight word is dropped, never acked.
    w_valid    = ((w_serv_a & i_req_a) | (w_serv_b & i_req_b)) & ~i_rst;
    w_xfer     = w_valid & i_out_ready;
    w_at_limit = (r_burst_cnt == LP_CNT_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_sel       <= SEL_A;
      r_last      <= SEL_B;
      r_gnt_a     <= 1'b0;
      r_gnt_b     <= 1'b0;
      r_burst_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_idle_go) begin
            r_state <= serv_state(w_idle_sel);
            r_sel   <= w_idle_sel;
            r_gnt_a <= (w_idle_sel == SEL_A);
            r_gnt_b <= (w_idle_sel == SEL_B);
          end
        end
        ST_SERV_A, ST_SERV_B: begin
          if (w_xfer) begin
            r_last <= w_own_sel;
          end
          if ((w_xfer && w_at_limit && w_req_oth) || (!w_req_own && w_req_oth)) begin
            r_state     <= serv_state(w_oth_sel);
            r_sel       <= w_oth_sel;
            r_gnt_a     <= (w_oth_sel == SEL_A);
            r_gnt_b     <= (w_oth_sel == SEL_B);
            r_burst_cnt <= 8'd0;
          end else if (!w_req_own) begin
            r_state     <= ST_IDLE;
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_burst_cnt <= 8'd0;
          end else if (w_xfer && !w_at_limit) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_gnt_a     <= 1'b0;
          r_gnt_b     <= 1'b0;
          r_burst_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign o_gnt_a     = r_gnt_a;
  assign o_gnt_b     = r_gnt_b;
  assign o_sel       = r_sel;
  assign o_out_valid = w_valid;
  assign o_ack_a     = w_xfer & w_serv_a;
  assign o_ack_b     = w_xfer & w_serv_b;

  mux_21_w #(
    .WIDTH(WIDTH)
  ) u_data_mux (
    .i_a(i_data_a),
    .i_b(i_data_b),
    .i_s(r_sel),
    .o_q(o_out_data)
  );

endmodule

// File: tb/tb_mux_21_arbiter.sv
// Directed and randomized checks of mux_21_arbiter against a behavioural
// owner/burst model kept in the bench.
module tb_mux_21_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_a, req_b, out_ready;
  logic [WIDTH-1:0] data_a, data_b;
  logic             gnt_a, gnt_b, ack_a, ack_b, sel, out_valid;
  logic [WIDTH-1:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  // Model: who owns the mux (0 none, 1 A, 2 B), words taken in this grant,
  // last side served, and the select the mux currently shows.
  int   m_own  = 0;
  int   m_cnt  = 0;
  int   m_last = 2;
  logic m_sel  = 1'b0;
  bit   m_ok   = 1'b0;

  always #5 clk = ~clk;

  mux_21_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_a(req_a), .i_data_a(data_a),
    .i_req_b(req_b), .i_data_b(data_b),
    .i_out_ready(out_ready),
    .o_gnt_a(gnt_a), .o_gnt_b(gnt_b),
    .o_ack_a(ack_a), .o_ack_b(ack_b),
    .o_sel(sel), .o_out_valid(out_valid),
    .o_out_data(out_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic ra, input logic rb,
                      input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                      input logic rdy);
    logic ev, ea, eb, own_req, oth_req, took;
    @(negedge clk);
    rst = r; req_a = ra; req_b = rb; data_a = da; data_b = db; out_ready = rdy;
    #1;
    ev = !r && ((m_own == 1 && ra) || (m_own == 2 && rb));
    ea = ev && rdy && (m_own == 1);
    eb = ev && rdy && (m_own == 2);
    if (m_ok) begin
      chk("ctrl{gnt_a,gnt_b,sel,ack_a,ack_b,valid}",
          {gnt_a, gnt_b, sel, ack_a, ack_b, out_valid},
          {(m_own == 1), (m_own == 2), m_sel, ea, eb, ev});
      chk("out_data", out_data, m_sel ? db : da);
    end
    if (r) begin
      m_own = 0; m_cnt = 0; m_last = 2; m_sel = 1'b0; m_ok = 1'b1;
    end else if (m_own == 0) begin
      if (ra && rb)  m_own = (m_last == 2) ? 1 : 2;
      else if (ra)   m_own = 1;
      else if (rb)   m_own = 2;
      if (m_own != 0) m_sel = (m_own == 2);
    end else begin
      own_req = (m_own == 1) ? ra : rb;
      oth_req = (m_own == 1) ? rb : ra;
      took    = ea | eb;
      if (took) m_last = m_own;
      if (took && (m_cnt + 1 >= MAX_BURST) && oth_req) begin
        m_own = 3 - m_own; m_cnt = 0; m_sel = (m_own == 2);
      end else if (!own_req) begin
        m_own = oth_req ? 3 - m_own : 0; m_cnt = 0;
        if (m_own != 0) m_sel = (m_own == 2);
      end else if (took && (m_cnt + 1 < MAX_BURST)) begin
        m_cnt++;
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h3C, 8'hC3, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h3C, 8'hC3, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, gb_seen;
    bit pend[2];
    logic [WIDTH-1:0] dat[2];
    logic r, rdy;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    data_a = '0; data_b = '0; out_ready = 1'b0;

    // Reset state and A-only streaming
    do_reset();
    chk("reset_outputs", {gnt_a, gnt_b, sel, ack_a, ack_b, out_valid}, 6'b0);
    chk("reset_out_data", out_data, 8'h3C);
    acks = 0; gb_seen = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'h3C, 8'h55, 1'b1);
      acks += int'(ack_a);
      gb_seen += int'(gnt_b);
      if (k == 1) chk("a_only_gnt_sel_data", {gnt_a, sel, out_data}, {1'b1, 1'b0, 8'h3C});
    end
    chk("a_only_ack_count", acks, 5);
    chk("a_only_gnt_b_seen", gb_seen, 0);

    // Continuous contention: 4 to A, 4 to B, no bubble
    do_reset();
    for (int k = 0; k < 17; k++) begin
      step(1'b0, 1'b1, 1'b1, 8'hA0, 8'hB0, 1'b1);
      if (k >= 1)
        chk("rr_pattern", {ack_a, ack_b}, (((k - 1) / MAX_BURST) % 2 == 0) ? 2'b10 : 2'b01);
    end

    // Tie goes to A after reset, then to B after A returns to IDLE
    do_reset();
    step(1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h11, 8'h22, 1'b1);
    chk("tie_first_a", {gnt_a, gnt_b}, 2'b10);
    step(1'b0, 1'b0, 1'b0, 8'h11, 8'h22, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
    chk("tie_second_b", {gnt_a, gnt_b, sel}, 3'b011);

    // B stalled by out_ready, then B aborts while A waits
    do_reset();
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h77, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00, 8'h77, 1'b0);
      chk("stall_b", {gnt_b, ack_b}, 2'b10);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h77, 1'b1);
    chk("stall_b_release", {ack_b, out_data}, {1'b1, 8'h77});
    step(1'b0, 1'b1, 1'b1, 8'h44, 8'h78, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h44, 8'h78, 1'b0);
    chk("abort_no_ack_b", ack_b, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h44, 8'h78, 1'b1);
    chk("abort_to_a", {gnt_a, sel, ack_a}, 3'b101);

    // Reset on the second transfer of an A burst
    do_reset();
    step(1'b0, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h5B, 8'h00, 1'b1);
    chk("reset_mid_burst_no_ack", {ack_a, ack_b, out_valid}, 3'b000);
    step(1'b0, 1'b0, 1'b0, 8'h5B, 8'h00, 1'b1);
    chk("after_reset_idle", {gnt_a, gnt_b, sel, ack_a, ack_b, out_valid}, 6'b0);
    step(1'b0, 1'b1, 1'b1, 8'h5B, 8'h66, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h5B, 8'h66, 1'b1);
    chk("after_reset_tie_a", {gnt_a, ack_a}, 2'b11);

    // Randomized requesters obeying hold-until-ack, with rare aborts/resets
    do_reset();
    pend[0] = 1'b0; pend[1] = 1'b0; dat[0] = '0; dat[1] = '0;
    for (int k = 0; k < 600; k++) begin
      for (int s = 0; s < 2; s++) begin
        if (!pend[s]) begin
          if ($urandom_range(0, 9) < 6) begin
            pend[s] = 1'b1; dat[s] = WIDTH'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          pend[s] = 1'b0;
        end
      end
      r   = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      step(r, pend[0], pend[1], dat[0], dat[1], rdy);
      if (ack_a) begin pend[0] = ($urandom_range(0, 3) != 0); dat[0] = WIDTH'($urandom); end
      if (ack_b) begin pend[1] = ($urandom_range(0, 3) != 0); dat[1] = WIDTH'($urandom); end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
